// File: rtl/serial_pkg.sv
// Shared definitions for the serial operand feeder: FSM encoding, default width
// and the bit-counter width helper.
package serial_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Counter must index 0..width-1; never narrower than one bit.
    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_operand_feeder_if.sv
// Parallel operand-pair input and LSB-first serial bit output of the feeder.
interface serial_operand_feeder_if
    import serial_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    // Handshakes: a transfer happens on a rising clk edge where valid & ready are
    // both 1; valid never waits on ready, and data is held while valid & ~ready.
    // in_valid/in_ready move (a, b, sub); bit_valid/bit_ready move one serial bit.
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             bit_ready;
    logic             bit_valid;
    logic             a_bit;
    logic             b_bit;
    logic             cin_init;
    logic             first;
    logic             last;
    logic             busy;

    modport master (
        input  in_valid, a, b, sub, bit_ready,
        output in_ready, bit_valid, a_bit, b_bit, cin_init, first, last, busy
    );

    modport slave (
        output in_valid, a, b, sub, bit_ready,
        input  in_ready, bit_valid, a_bit, b_bit, cin_init, first, last, busy
    );

endinterface

// File: rtl/serial_piso.sv
// Parallel-load, shift-right register; the LSB is the serial output.
module serial_piso
    import serial_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             lsb
);

    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_d;

    // Load wins over shift so a back-to-back frame replaces the finished one.
    always_comb begin
        sr_d = sr_q;
        if (load) begin
            sr_d = din;
        end else if (shift) begin
            sr_d = {1'b0, sr_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign lsb = sr_q[0];

endmodule

// File: rtl/serial_operand_feeder.sv
// Turns a parallel (a, b, sub) operand pair into an LSB-first bit stream for a
// serial adder; B is pre-inverted and cin_init seeded for subtraction.
module serial_operand_feeder
    import serial_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                    clk,
    input  logic                    clr,
    serial_operand_feeder_if.master io,
    output state_t                  dbg_state
);

    localparam int             CW      = cnt_width(WIDTH);
    localparam logic [CW-1:0]  CNT_MAX = CW'(WIDTH - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          cin_q, cin_d;

    logic shifting;
    logic last_beat;
    logic in_ready;
    logic accept;
    logic beat;
    logic load;
    logic shift;

    assign shifting  = (state_q == SHIFT);
    assign last_beat = shifting && (cnt_q == CNT_MAX);
    // Ready on the final beat too, so the next frame starts with no idle gap.
    assign in_ready  = ~clr & (~shifting | (last_beat & io.bit_ready));
    assign accept    = io.in_valid & in_ready;
    assign beat      = shifting & io.bit_ready;
    assign load      = accept;
    assign shift     = beat & ~last_beat;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cin_d   = cin_q;
        if (accept) begin
            state_d = SHIFT;
            cnt_d   = '0;
            cin_d   = io.sub;
        end else if (beat) begin
            if (last_beat) begin
                state_d = IDLE;
            end else begin
                cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cin_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cin_q   <= cin_d;
        end
    end

    serial_piso #(.WIDTH(WIDTH)) u_piso_a (
        .clk   (clk),
        .clr   (clr),
        .load  (load),
        .shift (shift),
        .din   (io.a),
        .lsb   (io.a_bit)
    );

    serial_piso #(.WIDTH(WIDTH)) u_piso_b (
        .clk   (clk),
        .clr   (clr),
        .load  (load),
        .shift (shift),
        .din   (io.b ^ {WIDTH{io.sub}}),
        .lsb   (io.b_bit)
    );

    assign io.in_ready  = in_ready;
    assign io.bit_valid = shifting;
    assign io.busy      = shifting;
    assign io.first     = shifting && (cnt_q == '0);
    assign io.last      = last_beat;
    assign io.cin_init  = cin_q;
    assign dbg_state    = state_q;

endmodule

// File: doc/serial_operand_feeder.md
SERIAL_OPERAND_FEEDER -- requirements
Module: serial_operand_feeder

Interface
REQ-001 Parameter WIDTH, default 8: operand width in bits; the legal range SHALL be 2..32.
REQ-002 Port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-003 Port clr, input, 1: reset; it SHALL be asynchronous and active-high.
REQ-004 Port in_valid, input, 1: the upstream operand pair (a, b, sub) is valid.
REQ-005 Port in_ready, output, 1: the feeder accepts an operand pair this cycle.
REQ-006 Port a, input, WIDTH: operand A, parallel.
REQ-007 Port b, input, WIDTH: operand B, parallel.
REQ-008 Port sub, input, 1: 1 selects A-B; 0 selects A+B.
REQ-009 Port bit_ready, input, 1: the downstream serial adder consumes the current bit this cycle.
REQ-010 Port bit_valid, output, 1: a_bit and b_bit carry a valid bit this cycle.
REQ-011 Port a_bit, output, 1: serial A, LSB first.
REQ-012 Port b_bit, output, 1: serial B (inverted when sub=1), LSB first.
REQ-013 Port cin_init, output, 1: carry seed for the frame; it SHALL equal the captured sub and be stable for the whole frame.
REQ-014 Port first, output, 1: marks bit 0 of a frame, qualified by bit_valid.
REQ-015 Port last, output, 1: marks bit WIDTH-1 of a frame, qualified by bit_valid.
REQ-016 Port busy, output, 1: a frame is in progress.

Function
REQ-017 The FSM SHALL have two states: IDLE and SHIFT.
REQ-018 In IDLE: in_ready=1 and bit_valid=0; on in_valid&in_ready, the block SHALL capture a, b^{WIDTH{sub}} and sub, clear the bit counter, and enter SHIFT.
REQ-019 In SHIFT: bit_valid=1; a_bit=sa[0], b_bit=sb[0], first=(cnt==0), last=(cnt==WIDTH-1).
REQ-020 On bit_valid&bit_ready with last=0, sa and sb SHALL shift right by one and cnt SHALL increment.
REQ-021 When bit_valid&bit_ready=0, all outputs and state SHALL hold unchanged (stall).
REQ-022 On bit_valid&bit_ready with last=1 and in_valid=0, the FSM SHALL return to IDLE.
REQ-023 in_ready SHALL equal (state==IDLE) | (state==SHIFT & last & bit_ready); it is combinational and the block stays zero-bubble.
REQ-024 On last&bit_ready&in_valid, the block SHALL load the new pair and remain in SHIFT; the next cycle SHALL present bit 0 of the new frame with first=1 and no idle gap.
REQ-025 in_valid while in SHIFT and not on the last beat SHALL be ignored; the upstream holds its data.
REQ-026 Latency: bit 0 SHALL appear on the cycle after acceptance. An unstalled frame SHALL take exactly WIDTH bit_valid cycles.
REQ-027 busy SHALL equal (state==SHIFT).
REQ-028 cnt SHALL be $clog2(WIDTH) bits wide, saturate at WIDTH-1, and never wrap within a frame.

Reset
REQ-029 While clr=1: state=IDLE, sa=sb=0, cnt=0, cin_init=0, and bit_valid, first, last, busy and in_ready SHALL all be 0.
REQ-030 clr asserted mid-frame SHALL abort the frame immediately (asynchronously) with no partial bits emitted afterwards; after release, in_ready=1 on the first cycle.

Structure
REQ-031 Package serial_pkg SHALL hold the state enum (IDLE, SHIFT), default WIDTH=8 and the count-width function.
REQ-032 One sub-module, serial_piso (WIDTH-bit parallel-load / shift-right register with load, shift and async clr), SHALL be instantiated twice, for A and B.

Verification
REQ-033 Add: a=8'hA5, b=8'h3C, sub=0, bit_ready=1 -> a_bit 1,0,1,0,0,1,0,1; b_bit 0,0,1,1,1,1,0,0; cin_init=0; first on beat 0, last on beat 7.
REQ-034 Subtract: a=8'h10, b=8'h01, sub=1 -> b_bit 0,1,1,1,1,1,1,1 (~8'h01); cin_init=1 for all 8 beats.
REQ-035 Back-to-back: second pair presented during the last beat -> in_ready=1 on that beat; 16 consecutive bit_valid cycles; first on beats 0 and 8.
REQ-036 Stall: bit_ready=0 for 3 cycles at beat 4 -> a_bit, b_bit and last held; the frame completes in 11 cycles with bits unchanged.
REQ-037 Reset mid-frame: clr pulsed at beat 5 -> bit_valid=0 at once; busy=0; after release, a new pair 8'hFF/8'h01 streams from beat 0 correctly.
